// File: rtl/mmu_translator.sv
// Virtual-to-physical translation front-end: CPU access -> tlb lookup -> physical bus access.
// A one-entry micro-TLB lets back-to-back accesses to the same page skip the tlb handshake.
module mmu_translator #(
   parameter int PAGE_BITS = 12,
   parameter int UTLB_EN   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        paging_en_i,
   input  logic        flush_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_data_i,
   input  logic        cpu_rd_i,
   input  logic        cpu_we_i,
   output logic [31:0] cpu_data_o,
   output logic        cpu_ack_o,
   output logic        cpu_fault_o,
   output logic [31:0] v_addr_o,
   output logic        v_lookup_o,
   input  logic [31:0] v_ent_i,
   input  logic        v_ack_i,
   input  logic        page_fault_i,
   output logic [31:0] addr_o,
   output logic [31:0] data_o,
   input  logic [31:0] data_i,
   output logic        rd_o,
   output logic        we_o,
   input  logic        ack_i,
   output logic [31:0] fault_addr_o,
   output logic        fault_write_o
);
   localparam int VPN_W = 32 - PAGE_BITS;

   typedef enum logic [2:0] {IDLE, LOOKUP, MEM, DONE, FAULT, RELEASE} state_t;

   state_t             state;
   logic [31:0]        va;
   logic               is_write;
   logic               utlb_valid;
   logic [VPN_W-1:0]   utlb_vpn;
   logic [VPN_W-1:0]   utlb_frame;
   logic               req;
   logic               utlb_hit;
   logic               pte_denied;
   logic               unused_pte_bits;

   assign req        = cpu_rd_i | cpu_we_i;
   assign utlb_hit   = (UTLB_EN != 0) && utlb_valid && (utlb_vpn == cpu_addr_i[31:PAGE_BITS]);
   assign pte_denied = !v_ent_i[0] || (is_write && !v_ent_i[1]);
   assign unused_pte_bits = ^v_ent_i[PAGE_BITS-1:2];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         va            <= '0;
         is_write      <= 1'b0;
         utlb_valid    <= 1'b0;
         utlb_vpn      <= '0;
         utlb_frame    <= '0;
         cpu_data_o    <= '0;
         cpu_ack_o     <= 1'b0;
         cpu_fault_o   <= 1'b0;
         v_addr_o      <= '0;
         v_lookup_o    <= 1'b0;
         addr_o        <= '0;
         data_o        <= '0;
         rd_o          <= 1'b0;
         we_o          <= 1'b0;
         fault_addr_o  <= '0;
         fault_write_o <= 1'b0;
      end else begin
         // completion strobes are single-cycle; they are raised only on the edge entering DONE/FAULT
         cpu_ack_o   <= 1'b0;
         cpu_fault_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  va       <= cpu_addr_i;
                  data_o   <= cpu_data_i;
                  is_write <= cpu_we_i;
                  if (!paging_en_i || utlb_hit) begin
                     addr_o <= paging_en_i ? {utlb_frame, cpu_addr_i[PAGE_BITS-1:0]} : cpu_addr_i;
                     rd_o   <= ~cpu_we_i;
                     we_o   <= cpu_we_i;
                     state  <= MEM;
                  end else begin
                     v_addr_o   <= cpu_addr_i;
                     v_lookup_o <= 1'b1;
                     state      <= LOOKUP;
                  end
               end
            end
            LOOKUP: begin
               if (page_fault_i || (v_ack_i && pte_denied)) begin
                  v_lookup_o    <= 1'b0;
                  cpu_ack_o     <= 1'b1;
                  cpu_fault_o   <= 1'b1;
                  fault_addr_o  <= va;
                  fault_write_o <= is_write;
                  state         <= FAULT;
               end else if (v_ack_i) begin
                  v_lookup_o <= 1'b0;
                  utlb_valid <= 1'b1;
                  utlb_vpn   <= va[31:PAGE_BITS];
                  utlb_frame <= v_ent_i[31:PAGE_BITS];
                  addr_o     <= {v_ent_i[31:PAGE_BITS], va[PAGE_BITS-1:0]};
                  rd_o       <= ~is_write;
                  we_o       <= is_write;
                  state      <= MEM;
               end
            end
            MEM: begin
               if (ack_i) begin
                  rd_o       <= 1'b0;
                  we_o       <= 1'b0;
                  cpu_data_o <= data_i;
                  cpu_ack_o  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE:    state <= RELEASE;
            FAULT:   state <= RELEASE;
            RELEASE: if (!req) state <= IDLE;
            default: state <= IDLE;
         endcase
         // placed after the fill so a simultaneous flush discards it
         if (flush_i) utlb_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mmu_translator.sv
// Randomised bench for mmu_translator: a page-level model of the micro-TLB predicts
// lookups, faults and physical addresses; tlb and memory are emulated with random latencies.
module tb_mmu_translator;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        paging_en_i = 1'b0, flush_i = 1'b0;
   logic [31:0] cpu_addr_i = '0, cpu_data_i = '0;
   logic        cpu_rd_i = 1'b0, cpu_we_i = 1'b0;
   logic [31:0] cpu_data_o;
   logic        cpu_ack_o, cpu_fault_o;
   logic [31:0] v_addr_o;
   logic        v_lookup_o;
   logic [31:0] v_ent_i = '0;
   logic        v_ack_i = 1'b0, page_fault_i = 1'b0;
   logic [31:0] addr_o, data_o;
   logic [31:0] data_i = '0;
   logic        rd_o, we_o;
   logic        ack_i = 1'b0;
   logic [31:0] fault_addr_o;
   logic        fault_write_o;

   int errors = 0;
   int checks = 0;

   // reference model: what the one-entry translation cache should hold, and last CPU data
   bit          m_valid = 0;
   logic [19:0] m_vpn = '0;
   logic [19:0] m_frame = '0;
   logic [31:0] m_data = '0;

   mmu_translator #(.PAGE_BITS(12), .UTLB_EN(1)) dut (
      .clk(clk), .rst(rst), .paging_en_i(paging_en_i), .flush_i(flush_i),
      .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_rd_i(cpu_rd_i), .cpu_we_i(cpu_we_i),
      .cpu_data_o(cpu_data_o), .cpu_ack_o(cpu_ack_o), .cpu_fault_o(cpu_fault_o),
      .v_addr_o(v_addr_o), .v_lookup_o(v_lookup_o), .v_ent_i(v_ent_i), .v_ack_i(v_ack_i),
      .page_fault_i(page_fault_i), .addr_o(addr_o), .data_o(data_o), .data_i(data_i),
      .rd_o(rd_o), .we_o(we_o), .ack_i(ack_i), .fault_addr_o(fault_addr_o),
      .fault_write_o(fault_write_o)
   );

   always #5 clk = ~clk;

   task automatic check_all_zero(input string name);
      logic [199:0] outs;
      outs = {cpu_data_o, cpu_ack_o, cpu_fault_o, v_addr_o, v_lookup_o, addr_o, data_o,
              rd_o, we_o, fault_addr_o, fault_write_o};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL %s: outputs=%h required all zero", name, outs);
      end
   endtask

   // One CPU access, emulating tlb and memory, checked against the model.
   task automatic do_access(input string name, input logic wr, input logic both,
                            input logic [31:0] va, input logic [31:0] wdata, input logic paging,
                            input logic [31:0] pte, input logic pf, input int tlb_dly,
                            input int mem_dly, input logic [31:0] rdata, input int hold,
                            input int flush_mode);
      bit          exp_lookup, exp_fault, saw_lookup, saw_mem, done, flushed;
      logic [31:0] exp_addr;
      int          cyc, lk, mc, first_mem;
      exp_lookup = paging && !(m_valid && m_vpn == va[31:12]);
      exp_fault  = exp_lookup && (pf || !pte[0] || (wr && !pte[1]));
      exp_addr   = !paging ? va : (exp_lookup ? {pte[31:12], va[11:0]} : {m_frame, va[11:0]});
      saw_lookup = 0; saw_mem = 0; done = 0; flushed = 0;
      cyc = 0; lk = 0; mc = 0; first_mem = -1;

      @(negedge clk);
      paging_en_i = paging;
      cpu_addr_i  = va;
      cpu_data_i  = wdata;
      cpu_we_i    = wr;
      cpu_rd_i    = !wr || both;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         v_ack_i = 0; page_fault_i = 0; ack_i = 0; flush_i = 0; data_i = $urandom;
         if (cpu_ack_o) begin
            done = 1;
         end else begin
            if (v_lookup_o) begin
               saw_lookup = 1;
               lk++;
               checks++;
               if (v_addr_o !== va) begin
                  errors++;
                  $display("FAIL %s v_addr: got %h need %h", name, v_addr_o, va);
               end
               if (lk > tlb_dly) begin
                  page_fault_i = pf;
                  v_ack_i      = pf ? 1'($urandom_range(0, 1)) : 1'b1;
                  v_ent_i      = pte;
                  if (flush_mode == 1) begin flush_i = 1; flushed = 1; end
               end
            end
            if (rd_o || we_o) begin
               checks++;
               if (addr_o !== exp_addr || rd_o !== !wr || we_o !== wr || (wr && data_o !== wdata)) begin
                  errors++;
                  $display("FAIL %s mem: addr=%h rd=%b we=%b data=%h need addr=%h rd=%b we=%b data=%h",
                           name, addr_o, rd_o, we_o, data_o, exp_addr, !wr, wr, wdata);
               end
               if (!saw_mem) begin
                  saw_mem = 1;
                  first_mem = cyc;
                  if (flush_mode == 2) begin flush_i = 1; flushed = 1; end
               end
               mc++;
               if (mc > mem_dly) begin ack_i = 1; data_i = rdata; end
            end
         end
      end
      v_ack_i = 0; page_fault_i = 0; ack_i = 0; flush_i = 0;

      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: no cpu_ack_o within 60 cycles, need one", name);
      end else begin
         checks++;
         if (cpu_fault_o !== exp_fault) begin
            errors++;
            $display("FAIL %s fault flag: got %b need %b", name, cpu_fault_o, exp_fault);
         end
         checks++;
         if (saw_lookup !== exp_lookup || saw_mem !== !exp_fault) begin
            errors++;
            $display("FAIL %s path: lookup=%b mem=%b need lookup=%b mem=%b",
                     name, saw_lookup, saw_mem, exp_lookup, !exp_fault);
         end
         if (!exp_lookup && !exp_fault) begin
            checks++;
            if (first_mem != 1) begin
               errors++;
               $display("FAIL %s latency: mem request at cycle %0d need 1", name, first_mem);
            end
         end
         checks++;
         if (exp_fault) begin
            if (fault_addr_o !== va || fault_write_o !== wr || cpu_data_o !== m_data) begin
               errors++;
               $display("FAIL %s fault info: addr=%h wr=%b data=%h need addr=%h wr=%b data=%h",
                        name, fault_addr_o, fault_write_o, cpu_data_o, va, wr, m_data);
            end
         end else if (cpu_data_o !== rdata) begin
            errors++;
            $display("FAIL %s cpu_data: got %h need %h", name, cpu_data_o, rdata);
         end
      end

      if (exp_lookup && !exp_fault) begin
         m_valid = 1; m_vpn = va[31:12]; m_frame = pte[31:12];
      end
      if (flushed) m_valid = 0;
      if (!exp_fault) m_data = rdata;

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checks++;
         if (cpu_ack_o || rd_o || we_o || v_lookup_o) begin
            errors++;
            $display("FAIL %s hold: ack=%b rd=%b we=%b lookup=%b need all 0",
                     name, cpu_ack_o, rd_o, we_o, v_lookup_o);
         end
      end
      cpu_rd_i = 0; cpu_we_i = 0;
      @(negedge clk);
      $display("tx %s: %s va=%h paging=%b lookup=%b fault=%b paddr=%h",
               name, wr ? "st" : "ld", va, paging, exp_lookup, exp_fault, exp_addr);
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      flush_i = 1;
      @(negedge clk);
      flush_i = 0;
      m_valid = 0;
   endtask

   task automatic test_reset();
      rst = 0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1;
      @(negedge clk);
   endtask

   task automatic test_identity();
      do_access("identity", 0, 0, 32'h0000_1234, 32'h0, 0, 32'h0, 0, 0, 2, 32'hDEAD_BEEF, 1, 0);
   endtask

   task automatic test_lookup_and_hit();
      do_access("lookup", 0, 0, 32'h0000_1456, 32'h0, 1, 32'h0001_0001, 0, 2, 3, 32'h1111_2222, 1, 0);
      do_access("utlb_hit", 0, 0, 32'h0000_1ABC, 32'h0, 1, 32'h0, 0, 0, 1, 32'h3333_4444, 1, 0);
      pulse_flush();
      do_access("after_flush", 0, 0, 32'h0000_1ABC, 32'h0, 1, 32'h0001_0001, 0, 1, 0, 32'h5555_6666, 1, 0);
   endtask

   task automatic test_faults();
      do_access("not_present", 0, 0, 32'h0000_2000, 32'h0, 1, 32'h0000_0000, 0, 1, 0, 32'h0, 2, 0);
      do_access("store_ro", 1, 0, 32'h0040_0010, 32'hCAFE_F00D, 1, 32'h000F_0001, 0, 0, 0, 32'h0, 1, 0);
      do_access("store_rw", 1, 1, 32'h0040_0010, 32'hCAFE_F00D, 1, 32'h000F_0003, 0, 0, 2, 32'h7777_8888, 1, 0);
      do_access("page_fault", 0, 0, 32'h0080_0004, 32'h0, 1, 32'h0012_3003, 1, 2, 0, 32'h0, 5, 0);
   endtask

   task automatic test_flush_races();
      // flush together with the fill: fill lost, next access to that page looks up again
      do_access("flush_at_fill", 0, 0, 32'h0000_3010, 32'h0, 1, 32'h0AB0_0003, 0, 1, 1, 32'h0102_0304, 1, 1);
      do_access("flush_in_mem", 0, 0, 32'h0000_3020, 32'h0, 1, 32'h0AC0_0003, 0, 0, 2, 32'h0506_0708, 1, 2);
      do_access("relookup", 0, 0, 32'h0000_3030, 32'h0, 1, 32'h0AD0_0003, 0, 0, 0, 32'h090A_0B0C, 1, 0);
   endtask

   task automatic test_random();
      logic [31:0] va, pte;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) pulse_flush();
         va = (32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 4095));
         if ($urandom_range(0, 1) == 1) va = va | 32'h0040_0000;
         pte = ($urandom & 32'hFFFF_F000) |
               (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h3);
         do_access("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), va, $urandom,
                   $urandom_range(0, 4) != 0, pte, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                   $urandom_range(1, 3), ($urandom_range(0, 5) < 4) ? 0 : $urandom_range(1, 2));
      end
   endtask

   task automatic test_reset_mid();
      int t;
      do_access("prime", 0, 0, 32'h0000_5004, 32'h0, 1, 32'h0055_0003, 0, 0, 0, 32'hABCD_0123, 1, 0);
      @(negedge clk);
      paging_en_i = 0; cpu_addr_i = 32'h0000_6000; cpu_rd_i = 1;
      t = 0;
      while (!rd_o && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (!rd_o) begin
         errors++;
         $display("FAIL reset_mid setup: rd_o=%b need 1", rd_o);
      end
      rst = 0;
      @(negedge clk);
      check_all_zero("reset_mid");
      cpu_rd_i = 0; rst = 1;
      m_valid = 0; m_data = 0;
      @(negedge clk);
      do_access("post_reset", 0, 0, 32'h0000_5008, 32'h0, 1, 32'h0056_0003, 0, 0, 0, 32'h2468_ACE0, 1, 0);
   endtask

   initial begin
      test_reset();
      test_identity();
      test_lookup_and_hit();
      test_faults();
      test_flush_races();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mmu_translator.md
Name: mmu_translator

Overview:
- Translation front-end sitting directly upstream of tlb, between the CPU load/store port and the physical memory bus.
- Takes a CPU virtual access, requests a page-table entry from tlb via the v_lookup/v_ack handshake, forms the physical address, runs the access on the memory bus, and returns data or a fault to the CPU.
- Holds a one-entry micro-TLB so repeated accesses to the same page skip the lookup.

Parameters:
- PAGE_BITS, 12, page offset width; VPN is addr[31:PAGE_BITS].
- UTLB_EN, 1, 1 enables the one-entry micro-TLB; 0 forces a tlb lookup on every access.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 at posedge resets).
- paging_en_i  in  1  0 = identity mapping, no lookup.
- flush_i  in  1  pulse on mmu base write; invalidates micro-TLB.
- cpu_addr_i  in  32  virtual address.
- cpu_data_i  in  32  store data.
- cpu_rd_i  in  1  load request, held until cpu_ack_o.
- cpu_we_i  in  1  store request, held until cpu_ack_o.
- cpu_data_o  out  32  load data, valid with cpu_ack_o.
- cpu_ack_o  out  1  one-cycle completion pulse.
- cpu_fault_o  out  1  high with cpu_ack_o when the access faulted.
- v_addr_o  out  32  address presented to tlb.
- v_lookup_o  out  1  lookup request, held until v_ack_i or page_fault_i.
- v_ent_i  in  32  PTE from tlb: [31:12] frame, [1] writable, [0] present.
- v_ack_i  in  1  tlb entry valid.
- page_fault_i  in  1  tlb walk fault.
- addr_o  out  32  physical address.
- data_o  out  32  physical store data.
- data_i  in  32  physical load data.
- rd_o  out  1  memory read, held until ack_i.
- we_o  out  1  memory write, held until ack_i.
- ack_i  in  1  memory completion.
- fault_addr_o  out  32  faulting virtual address; holds until next fault.
- fault_write_o  out  1  1 if the faulting access was a store.

Behaviour:
- Reset: all outputs 0, state IDLE, micro-TLB invalid, fault_addr_o=0.
- States: IDLE, LOOKUP, MEM, DONE, FAULT, RELEASE.
- IDLE, request detected (cpu_rd_i|cpu_we_i):
  - Latch address, data and direction.
  - paging_en_i=0: go to MEM with addr_o=cpu_addr_i.
  - Otherwise, micro-TLB hit (valid and VPN match): go to MEM with addr_o={pte[31:12],va[11:0]}.
  - Otherwise: go to LOOKUP.
  - rd and we both high: treat as write.
- Latency: identity mapping or micro-TLB hit gives rd_o/we_o asserted the cycle after the request is first sampled.
- LOOKUP:
  - v_lookup_o=1 and v_addr_o=latched VA for the whole state.
  - page_fault_i (takes priority over v_ack_i) goes to FAULT.
  - v_ack_i with v_ent_i[0]=0 goes to FAULT.
  - v_ack_i on a store with v_ent_i[1]=0 goes to FAULT.
  - Otherwise: fill the micro-TLB, drive addr_o and go to MEM. v_lookup_o drops on the same edge.
- MEM: rd_o or we_o held with stable addr_o/data_o. On ack_i, capture data_i into cpu_data_o and go to DONE.
- DONE: cpu_ack_o=1 for exactly one cycle, then RELEASE.
- FAULT:
  - cpu_ack_o=1 and cpu_fault_o=1 for exactly one cycle.
  - fault_addr_o and fault_write_o updated on the same edge.
  - No memory access is issued. Then RELEASE.
- RELEASE: wait until cpu_rd_i=cpu_we_i=0, then IDLE. This prevents a held request from being re-issued.
- flush_i:
  - Clears the micro-TLB valid bit on the same edge in any state.
  - A fill in the same cycle as flush_i is discarded; flush wins.
  - An in-flight access completes with its already-translated address.
- cpu_data_o holds its last value between accesses.
- Reset mid-operation: return to IDLE immediately and drop all requests. The external device is expected to be reset too.

Test Plan:
- Paging off, load VA 0x0000_1234, mem returns 0xDEAD_BEEF -> no v_lookup_o; addr_o=0x0000_1234; cpu_ack_o pulse with cpu_data_o=0xDEAD_BEEF.
- Paging on, load VA 0x0000_1456, tlb acks v_ent_i=0x0001_0001 -> addr_o=0x0001_0456, rd_o held until ack_i; one-cycle cpu_ack_o.
- Repeat load VA 0x0000_1ABC -> no v_lookup_o (micro-TLB hit); rd_o the cycle after request; addr_o=0x0001_0ABC. Then pulse flush_i and repeat -> v_lookup_o reasserts.
- Load VA 0x0000_2000, tlb acks v_ent_i=0x0000_0000 -> cpu_ack_o=cpu_fault_o=1 for one cycle; fault_addr_o=0x0000_2000; fault_write_o=0; rd_o never asserted.
- Store VA 0x0040_0010 with v_ent_i=0x000F_0001 -> fault, fault_write_o=1. With v_ent_i=0x000F_0003 -> we_o, addr_o=0x000F_0010, data_o=cpu_data_i.
- page_fault_i during LOOKUP, and CPU holding rd for 5 cycles after ack -> single fault pulse; no second access until rd drops. Reset asserted in MEM -> all outputs 0 on the next edge.
